// File: rtl/mux_rr_sched.sv
// Purpose : round-robin scheduler driving the select of a registered 4:1 channel mux,
//           with a programmable dwell per grant and a valid/channel tag aligned to the mux output.
// Latency : a request seen at edge k is granted after edge k; out_valid/out_ch lag busy/sel by one cycle.
// Backpressure: none. A grant runs until its dwell expires or its request drops. Lowering enable only
//           blocks new grants and never preempts the grant in progress.
// Ports   : clk, rst (async, active-high); enable; req[3:0]; dwell[DWELL_W-1:0] ->
//           sel[1:0], gnt[3:0] (one-hot), busy, out_valid, out_ch[1:0].
module mux_rr_sched #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [3:0]         req,
    input  logic [DWELL_W-1:0] dwell,
    output logic [1:0]         sel,
    output logic [3:0]         gnt,
    output logic               busy,
    output logic               out_valid,
    output logic [1:0]         out_ch
);

    typedef enum logic {IDLE, HOLD} state_t;

    state_t             state, state_nxt;
    logic [DWELL_W-1:0] cnt, cnt_nxt;
    logic [1:0]         last, last_nxt;
    logic [1:0]         sel_nxt;
    logic [1:0]         winner;
    logic               found;
    logic [1:0]         cand;
    logic               can_grant;
    logic               release_now;
    logic               grant;

    // Search last+1, last+2, last+3, then last. The channel just served is
    // the final candidate, so it is re-granted only when no other channel asks.
    always_comb begin
        winner = last;
        found  = 1'b0;
        cand   = '0;
        for (int i = 1; i <= 4; i++) begin
            cand = last + 2'(i);
            if (!found && req[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    assign can_grant   = enable && (req != 4'b0000);
    // Release on dwell expiry or on an early drop of the served request.
    assign release_now = (cnt == '0) || !req[sel];

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel       <= 2'd0;
            cnt       <= '0;
            last      <= 2'd3;
            out_valid <= 1'b0;
            out_ch    <= 2'd0;
        end else begin
            state     <= state_nxt;
            sel       <= sel_nxt;
            cnt       <= cnt_nxt;
            last      <= last_nxt;
            // Mirror the mux's own output flop so the tag matches the data on out.
            out_valid <= busy;
            out_ch    <= sel;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        sel_nxt   = sel;
        last_nxt  = last;
        grant     = 1'b0;
        case (state)
            IDLE: begin
                if (can_grant) grant = 1'b1;
            end
            HOLD: begin
                if (release_now) begin
                    if (can_grant) grant = 1'b1;
                    else           state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - DWELL_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A grant at release time chains straight into the next HOLD with no idle cycle.
        if (grant) begin
            state_nxt = HOLD;
            sel_nxt   = winner;
            last_nxt  = winner;
            // A dwell of 0 behaves like 1; the counter holds remaining cycles minus one.
            cnt_nxt   = (dwell == '0) ? '0 : dwell - DWELL_W'(1);
        end
    end

    // Outputs
    always_comb begin
        busy = (state == HOLD);
        gnt  = busy ? (4'b0001 << sel) : 4'b0000;
    end

endmodule
